// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Shares the single register-file write port between the execute
//   writeback source and the load-return source. Load returns are buffered
//   in a circular queue. Execute is refused while loads are queued, but only
//   for up to MAX_WAIT consecutive cycles. The granted source is written
//   into registered rf_we / rf_waddr / rf_wdata.
//
//   Optional build macro: WB_BYPASS_EN
//     Defined   - a lone load (queue empty, no execute request) is granted
//                 directly and writes one cycle after acceptance.
//     Undefined - every load goes through the queue (two-cycle minimum).
//
// Ports
//   clk, rst_n          clock, async active-low reset
//   ex_valid/ex_ready   execute writeback handshake
//   ex_rd, ex_sel       destination, data select (00 ALU, 11 PC+4, else 0)
//   ex_alu, ex_pc4      execute data candidates
//   ld_valid/ld_ready   load-return handshake
//   ld_rd, ld_data      load destination and extended data
//   rf_we/waddr/wdata   registered register-file write port
//   lq_count            load-queue occupancy
module wb_port_arbiter #(
    parameter int LQ_DEPTH = 4,
    parameter int MAX_WAIT = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ex_valid,
    output logic                          ex_ready,
    input  logic [4:0]                    ex_rd,
    input  logic [1:0]                    ex_sel,
    input  logic [31:0]                   ex_alu,
    input  logic [31:0]                   ex_pc4,
    input  logic                          ld_valid,
    output logic                          ld_ready,
    input  logic [4:0]                    ld_rd,
    input  logic [31:0]                   ld_data,
    output logic                          rf_we,
    output logic [4:0]                    rf_waddr,
    output logic [31:0]                   rf_wdata,
    output logic [$clog2(LQ_DEPTH+1)-1:0] lq_count
);

    localparam int PW = $clog2(LQ_DEPTH);
    localparam int CW = $clog2(LQ_DEPTH + 1);
    localparam int WW = $clog2(MAX_WAIT + 1);

    logic [4:0]    lq_rd   [LQ_DEPTH];
    logic [31:0]   lq_data [LQ_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [WW-1:0] wait_cnt;

    logic          ex_grant;
    logic          lq_grant;
    logic          byp_grant;
    logic          any_grant;
    logic          push;
    logic          pop;
    logic [31:0]   ex_wdata;
    logic [4:0]    g_rd;
    logic [31:0]   g_data;

    assign ld_ready = (lq_count < CW'(LQ_DEPTH));
    assign ex_ready = (lq_count == '0) || (wait_cnt == WW'(MAX_WAIT));

    assign ex_grant = ex_valid && ex_ready;
    assign lq_grant = !ex_grant && (lq_count != '0);

`ifdef WB_BYPASS_EN
    // Only possible with an empty queue and no execute request, so it never
    // competes with either of the other grants.
    assign byp_grant = (lq_count == '0) && ld_valid && !ex_valid;
`else
    assign byp_grant = 1'b0;
`endif

    assign any_grant = ex_grant || lq_grant || byp_grant;
    assign push      = ld_valid && ld_ready && !byp_grant;
    assign pop       = lq_grant;

    // Illegal selects write zero; the write itself still happens.
    always_comb begin
        ex_wdata = 32'h0;
        case (ex_sel)
            2'b00:   ex_wdata = ex_alu;
            2'b11:   ex_wdata = ex_pc4;
            default: ex_wdata = 32'h0;
        endcase
    end

    always_comb begin
        g_rd   = lq_rd[rd_ptr];
        g_data = lq_data[rd_ptr];
        if (ex_grant) begin
            g_rd   = ex_rd;
            g_data = ex_wdata;
        end else if (byp_grant) begin
            g_rd   = ld_rd;
            g_data = ld_data;
        end
    end

    // Queue storage needs no reset: the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            lq_rd[wr_ptr]   <= ld_rd;
            lq_data[wr_ptr] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            lq_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PW'(LQ_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(LQ_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   lq_count <= lq_count + CW'(1);
                2'b01:   lq_count <= lq_count - CW'(1);
                default: lq_count <= lq_count;
            endcase
        end
    end

    // Counts consecutive refused execute cycles; at MAX_WAIT execute wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (!ex_valid || ex_grant) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WW'(MAX_WAIT)) begin
            wait_cnt <= wait_cnt + WW'(1);
        end
    end

    // x0 writes still consume the grant but leave rf_we low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= 5'd0;
            rf_wdata <= 32'h0;
        end else if (any_grant) begin
            rf_we    <= (g_rd != 5'd0);
            rf_waddr <= g_rd;
            rf_wdata <= g_data;
        end else begin
            rf_we    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [4:0]  ex_rd;
    logic [1:0]  ex_sel;
    logic [31:0] ex_alu;
    logic [31:0] ex_pc4;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [2:0]  lq_count;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_ld;

    // Hand-derived for LQ_DEPTH=4, MAX_WAIT=3 with ex_valid held high and
    // one load offered every cycle 0..14 (cycle 13 is refused: queue full).
    int lq_tab  [20] = '{0,1,1,1,1,2,2,2,2,3,3,3,3,4,3,3,2,2,1,0};
    int exr_tab [20] = '{1,0,0,0,1,0,0,0,1,0,0,0,1,0,0,0,1,0,0,1};

    wb_port_arbiter #(.LQ_DEPTH(4), .MAX_WAIT(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ex_valid (ex_valid),
        .ex_ready (ex_ready),
        .ex_rd    (ex_rd),
        .ex_sel   (ex_sel),
        .ex_alu   (ex_alu),
        .ex_pc4   (ex_pc4),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .ld_rd    (ld_rd),
        .ld_data  (ld_data),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .lq_count (lq_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        ex_valid = 1'b0; ex_rd = 5'd0; ex_sel = 2'b00; ex_alu = 32'h0; ex_pc4 = 32'h0;
        ld_valid = 1'b0; ld_rd = 5'd0; ld_data = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_seq(input int ncyc);
        logic [4:0] next_rd;
        next_rd = 5'd1;
        exp_ld  = 1;
        for (int c = 0; c < ncyc; c++) begin
            ex_valid = 1'b1; ex_rd = 5'd31; ex_sel = 2'b00; ex_alu = 32'hE000_0000 + c;
            ld_valid = (c <= 14); ld_rd = next_rd; ld_data = 32'h1000 + next_rd;
            #1;
            check_val($sformatf("seq%0d lq_count", c), 32'(lq_count), lq_tab[c]);
            check_val($sformatf("seq%0d ex_ready", c), 32'(ex_ready), exr_tab[c]);
            check_val($sformatf("seq%0d ld_ready", c), 32'(ld_ready), (c == 13) ? 0 : 1);
            tick();
            if (c != 13 && c <= 14) next_rd = next_rd + 5'd1;
            check_val($sformatf("seq%0d rf_we", c), 32'(rf_we), 1);
            if (exr_tab[c] == 1) begin
                check_val($sformatf("seq%0d ex waddr", c), 32'(rf_waddr), 31);
                check_val($sformatf("seq%0d ex wdata", c), rf_wdata, 32'hE000_0000 + c);
            end else begin
                check_val($sformatf("seq%0d ld waddr", c), 32'(rf_waddr), exp_ld);
                check_val($sformatf("seq%0d ld wdata", c), rf_wdata, 32'h1000 + exp_ld);
                exp_ld++;
            end
        end
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check_val("rst rf_we",    32'(rf_we), 0);
        check_val("rst rf_waddr", 32'(rf_waddr), 0);
        check_val("rst rf_wdata", rf_wdata, 0);
        check_val("rst lq_count", 32'(lq_count), 0);
        check_val("rst ld_ready", 32'(ld_ready), 1);
        check_val("rst ex_ready", 32'(ex_ready), 1);
        tick();

        // Execute only
        ex_valid = 1'b1; ex_rd = 5'd5; ex_sel = 2'b11; ex_pc4 = 32'h104; ex_alu = 32'hAAAA;
        tick();
        check_val("ex pc4 we",    32'(rf_we), 1);
        check_val("ex pc4 waddr", 32'(rf_waddr), 5);
        check_val("ex pc4 wdata", rf_wdata, 32'h104);
        ex_rd = 5'd6; ex_sel = 2'b00; ex_alu = 32'h55;
        tick();
        check_val("ex alu waddr", 32'(rf_waddr), 6);
        check_val("ex alu wdata", rf_wdata, 32'h55);
        ex_rd = 5'd7; ex_sel = 2'b01;
        tick();
        check_val("ex ill we",    32'(rf_we), 1);
        check_val("ex ill wdata", rf_wdata, 32'h0);
        ex_rd = 5'd0; ex_sel = 2'b11;
        tick();
        check_val("ex x0 we",    32'(rf_we), 0);
        check_val("ex x0 waddr", 32'(rf_waddr), 0);

        // Simultaneous execute and load, empty queue
        ex_valid = 1'b1; ex_rd = 5'd3; ex_sel = 2'b00; ex_alu = 32'h33;
        ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h99;
        tick();
        check_val("sim N+1 waddr", 32'(rf_waddr), 3);
        check_val("sim N+1 wdata", rf_wdata, 32'h33);
        check_val("sim lq_count",  32'(lq_count), 1);
        idle_inputs();
        tick();
        check_val("sim N+2 we",    32'(rf_we), 1);
        check_val("sim N+2 waddr", 32'(rf_waddr), 9);
        check_val("sim N+2 wdata", rf_wdata, 32'h99);
        check_val("sim drained",   32'(lq_count), 0);

        // Lone load
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'hDEADBEEF;
        tick();
        idle_inputs();
`ifdef WB_BYPASS_EN
        check_val("lone N+1 we",    32'(rf_we), 1);
        check_val("lone N+1 waddr", 32'(rf_waddr), 7);
        check_val("lone N+1 wdata", rf_wdata, 32'hDEADBEEF);
        check_val("lone lq_count",  32'(lq_count), 0);
        tick();
        check_val("lone N+2 we",    32'(rf_we), 0);
        check_val("lone hold addr", 32'(rf_waddr), 7);
`else
        check_val("lone N+1 we",    32'(rf_we), 0);
        check_val("lone lq_count",  32'(lq_count), 1);
        tick();
        check_val("lone N+2 we",    32'(rf_we), 1);
        check_val("lone N+2 waddr", 32'(rf_waddr), 7);
        check_val("lone N+2 wdata", rf_wdata, 32'hDEADBEEF);
        tick();
        check_val("lone idle we",   32'(rf_we), 0);
        check_val("lone hold data", rf_wdata, 32'hDEADBEEF);
`endif

        // Queue fill, full hold-off, starvation release and in-order drain
        tick();
        run_seq(20);
        check_val("seq loads retired", exp_ld, 15);
        idle_inputs();
        tick();
        check_val("seq idle we",  32'(rf_we), 0);
        check_val("seq idle lq",  32'(lq_count), 0);

        // Reset mid-stream with three loads queued
        run_seq(9);
        idle_inputs();
        check_val("pre-rst lq_count", 32'(lq_count), 3);
        #2 rst_n = 1'b0;
        #1;
        check_val("async rst lq_count", 32'(lq_count), 0);
        check_val("async rst rf_we",    32'(rf_we), 0);
        check_val("async rst rf_waddr", 32'(rf_waddr), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val($sformatf("post-rst%0d rf_we", i), 32'(rf_we), 0);
            check_val($sformatf("post-rst%0d ld_ready", i), 32'(ld_ready), 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
Sequences the single register-file write port of the RV32I core between two writeback sources. The execute source carries an ALU result or PC+4, selected by a 2-bit writeback select. The load source carries data-memory return data, which arrives with variable latency. Load returns are buffered in a small queue. A starvation counter guarantees execute progress, and the result drives registered write-enable, address and data into the register file.

Parameters:
LQ_DEPTH, 4, load-return queue depth in entries; power of two, >= 2
MAX_WAIT, 3, max consecutive cycles execute may be refused while the load queue is non-empty; >= 1

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
ex_valid  in  1  execute writeback request
ex_ready  out  1  execute request accepted this cycle when ex_valid=1
ex_rd  in  5  execute destination register
ex_sel  in  2  writeback select: 00 ALU result, 11 PC+4, 01/10 illegal
ex_alu  in  32  ALU result
ex_pc4  in  32  PC+4 for JAL/JALR
ld_valid  in  1  load return valid
ld_ready  out  1  load queue can accept
ld_rd  in  5  load destination register
ld_data  in  32  load data, already sign/zero-extended
rf_we  out  1  register-file write enable, registered
rf_waddr  out  5  register-file write address, registered
rf_wdata  out  32  register-file write data, registered
lq_count  out  $clog2(LQ_DEPTH+1)  current load-queue occupancy

Behaviour:
- Reset (async, rst_n=0): rf_we=0, rf_waddr=0, rf_wdata=0, queue empty, lq_count=0, wait_cnt=0. Queued entries are discarded, including on reset mid-operation. After release: ld_ready=1, ex_ready=1.
- Load queue: circular FIFO of {rd, data}.
  - ld_ready = (lq_count < LQ_DEPTH). There is no pass-through when full.
  - Push on ld_valid && ld_ready.
  - Pop when the queue head is granted.
  - Push and pop in the same cycle leave lq_count unchanged.
  - Pointers wrap modulo LQ_DEPTH.
- ex_ready = (lq_count == 0) || (wait_cnt == MAX_WAIT). ex_ready must not depend on ex_valid.
- Arbitration, evaluated each cycle:
  - Execute grant = ex_valid && ex_ready.
  - Otherwise load grant = (lq_count != 0).
  - At most one grant per cycle.
- wait_cnt:
  - Increments, saturating at MAX_WAIT, when ex_valid && !ex_ready.
  - Clears on an execute grant or when ex_valid=0.
- Execute data: ex_sel 00 -> ex_alu; 11 -> ex_pc4; 01/10 -> 32'h0, with the write otherwise performed normally.
- Output register, on a grant:
  - rf_we <= (rd != 0). x0 writes consume the grant but are suppressed.
  - rf_waddr <= rd; rf_wdata <= selected data.
- Output register, with no grant: rf_we <= 0; rf_waddr and rf_wdata hold their previous values.
- Latency:
  - Execute accepted at cycle N -> rf_we at N+1.
  - Load accepted at N -> rf_we no earlier than N+2.
- Simultaneous ex_valid and ld_valid with an empty queue: execute is granted and the load is pushed. The load writes at N+2.
- Ordering: load returns retire in acceptance order. There is no ordering between the execute and load streams; the hazard unit owns that.

Optional Feature:
WB_BYPASS_EN
- Defined: when lq_count==0, ld_valid=1 and ex_valid=0, the load bypasses the queue. It is granted directly, is not pushed, and writes at N+1. lq_count stays 0.
- Undefined: every load is pushed, giving minimum load latency of 2 cycles.

Test Plan:
- Reset mid-stream: 3 loads queued, rst_n pulsed low asynchronously -> immediately lq_count=0 and rf_we=0; after release, no stale writes and ld_ready=1.
- Execute only: ex_valid=1, ex_rd=5, ex_sel=11, ex_pc4=0x104 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x104. Repeat with ex_rd=0 -> rf_we=0.
- Load queue full: 4 back-to-back loads while ex_valid holds the port -> lq_count=4 and ld_ready=0. The 5th load is held until a pop. Writes then drain in order rd=1,2,3,4.
- Starvation: MAX_WAIT=3, queue holds 4 loads, ex_valid=1 throughout -> loads granted for 3 cycles, execute granted on the 4th, remaining load drains after.
- Simultaneous requests with empty queue: ex_valid and ld_valid at cycle N -> execute write at N+1, load write at N+2.
- Bypass (WB_BYPASS_EN defined): lone load rd=7, data 0xDEADBEEF at N -> rf_we=1 at N+1 and lq_count stays 0. Without the macro the write lands at N+2.
